// File: rtl/dma_timing_control_pkg.sv
// Shared constants and types for the DMA timing/arbitration block.
// Covers the channel count, FSM states, transfer types and command-bit positions.
package dmaRegConfigPkg;
    localparam int CHANNELS    = 4;
    localparam int CMD_DISABLE = 2;
    localparam int CMD_ROTATE  = 4;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        XFER_VERIFY  = 2'b00,
        XFER_WRITE   = 2'b01,
        XFER_READ    = 2'b10,
        XFER_ILLEGAL = 2'b11
    } xfer_t;

    function automatic logic [1:0] onehot_to_idx(input logic [CHANNELS-1:0] oh);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction
endpackage

// File: rtl/dma_priority_resolver.sv
// Combinational channel picker: fixed (ch0 highest) or rotating from rotation_ptr.
// The grant is one-hot, or zero when nothing is eligible.
module dma_priority_resolver
    import dmaRegConfigPkg::*;
(
    input  logic [CHANNELS-1:0] eligible,
    input  logic [1:0]          rotation_ptr,
    input  logic                rotate,
    output logic [CHANNELS-1:0] grant
);
    logic       found;
    logic [1:0] base;
    logic [1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        base  = rotate ? rotation_ptr : 2'd0;
        // Walk channels starting at the highest-priority slot; 2-bit index wraps.
        for (int i = 0; i < CHANNELS; i++) begin
            idx = base + 2'(i);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dma_timing_control.sv
// Arbitration, HRQ/HLDA handshake and single-transfer timing for the 4-channel DMA.
// All outputs are Moore-decoded from the registered state and latched grant.
module dma_timing_control
    import dmaRegConfigPkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [CHANNELS-1:0]   DREQ,
    input  logic                  HLDA,
    input  logic                  EOP_N,
    input  logic [7:0]            commandReg,
    input  logic [CHANNELS-1:0]   maskReg,
    input  logic [2*CHANNELS-1:0] modeXfer,
    input  logic                  tcIn,
    output logic                  HRQ,
    output logic [CHANNELS-1:0]   DACK,
    output logic                  AEN,
    output logic                  ADSTB,
    output logic                  MEMR_N,
    output logic                  MEMW_N,
    output logic                  IOR_N,
    output logic                  IOW_N,
    output logic                  loadAddr,
    output logic                  updateCurrentAddressReg,
    output logic                  updateCurrentWordCountReg,
    output logic                  intEOP,
    output logic                  programCondition,
    output state_t                fsm_state
);
    state_t              state, next_state;
    logic [CHANNELS-1:0] grant, arb_grant, eligible;
    logic [1:0]          rot_ptr, grant_idx;
    logic                eop_seen;
    xfer_t               xfer;
    logic                is_read, is_write;
    logic                unused_cmd_bits;

    assign unused_cmd_bits = ^{commandReg[7:5], commandReg[3], commandReg[1:0]};

    assign eligible  = commandReg[CMD_DISABLE] ? '0 : (DREQ & ~maskReg);
    assign grant_idx = onehot_to_idx(grant);
    assign xfer      = xfer_t'(modeXfer[{grant_idx, 1'b0} +: 2]);
    assign is_read   = (xfer == XFER_READ);
    assign is_write  = (xfer == XFER_WRITE);
    assign fsm_state = state;

    dma_priority_resolver u_resolver (
        .eligible     (eligible),
        .rotation_ptr (rot_ptr),
        .rotate       (commandReg[CMD_ROTATE]),
        .grant        (arb_grant)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= SI;
        else       state <= next_state;
    end

    // Grant is latched only in SI, so command/mask changes never disturb a transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant    <= '0;
            rot_ptr  <= 2'd0;
            eop_seen <= 1'b0;
        end else begin
            case (state)
                SI: begin
                    grant    <= arb_grant;
                    eop_seen <= 1'b0;
                end
                S2, S3: if (!EOP_N) eop_seen <= 1'b1;
                S4:     rot_ptr <= grant_idx + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SI: if (|eligible) next_state = S0;
            S0: begin
                if (!(|(grant & DREQ))) next_state = SI;
                else if (HLDA)          next_state = S1;
            end
            S1:      next_state = HLDA ? S2 : SI;
            S2:      next_state = HLDA ? S3 : SI;
            S3:      next_state = HLDA ? S4 : SI;
            default: next_state = SI;
        endcase
    end

    always_comb begin
        HRQ                       = (state != SI);
        DACK                      = '0;
        AEN                       = 1'b0;
        ADSTB                     = 1'b0;
        MEMR_N                    = 1'b1;
        MEMW_N                    = 1'b1;
        IOR_N                     = 1'b1;
        IOW_N                     = 1'b1;
        loadAddr                  = 1'b0;
        updateCurrentAddressReg   = 1'b0;
        updateCurrentWordCountReg = 1'b0;
        intEOP                    = 1'b0;
        programCondition          = (state == SI) && !HLDA;
        if (state inside {S1, S2, S3, S4}) begin
            AEN  = 1'b1;
            DACK = grant;
        end
        case (state)
            S1: begin
                ADSTB    = 1'b1;
                loadAddr = 1'b1;
            end
            S2: begin
                MEMR_N = !is_read;
                IOR_N  = !is_write;
            end
            S3: begin
                MEMR_N = !is_read;
                IOR_N  = !is_write;
                IOW_N  = !is_read;
                MEMW_N = !is_write;
            end
            S4: begin
                updateCurrentAddressReg   = 1'b1;
                updateCurrentWordCountReg = 1'b1;
                intEOP                    = tcIn | eop_seen;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dma_timing_control.sv
// Randomized scoreboard bench for dma_timing_control.
// The driver predicts each transfer and queues it; the monitor checks the cycle-by-cycle strobes.
module tb_dma_timing_control;
    import dmaRegConfigPkg::*;

    logic        CLK, RESET, HLDA, EOP_N, tcIn;
    logic [3:0]  DREQ, maskReg;
    logic [7:0]  commandReg, modeXfer;
    logic        HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N;
    logic [3:0]  DACK;
    logic        loadAddr, updA, updW, intEOP, programCondition;
    state_t      fsm_state;

    dma_timing_control dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
        .commandReg(commandReg), .maskReg(maskReg), .modeXfer(modeXfer), .tcIn(tcIn),
        .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .loadAddr(loadAddr), .updateCurrentAddressReg(updA),
        .updateCurrentWordCountReg(updW), .intEOP(intEOP),
        .programCondition(programCondition), .fsm_state(fsm_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int done   = 0;
    int ptr_m  = 0;
    // record: {abort_stage[1:0], exp_eop, xfer_type[1:0], grant[3:0]}
    logic [8:0] exp_q[$];

    logic [15:0] out_vec;
    assign out_vec = {HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
                      loadAddr, updA, updW, intEOP, programCondition};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus picture for a stage: 0 idle, 1 address, 2 read, 3 write, 4 finish.
    function automatic logic [15:0] exp_vec(input int stage, input logic [3:0] g,
                                            input logic [1:0] t, input bit eop, input logic hlda);
        bit rd, wr, strb;
        rd   = (t == 2'b10);
        wr   = (t == 2'b01);
        strb = (stage == 2) || (stage == 3);
        return {stage != 0, (stage >= 1) ? g : 4'b0000, stage >= 1, stage == 1,
                !(strb && rd), !(stage == 3 && wr), !(strb && wr), !(stage == 3 && rd),
                stage == 1, stage == 4, stage == 4, (stage == 4) && eop,
                (stage == 0) && !hlda};
    endfunction

    function automatic int arb(input logic [3:0] elig, input bit rot);
        int start;
        start = rot ? ptr_m : 0;
        for (int i = 0; i < 4; i++) begin
            if (elig[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; HLDA = 1'b0; DREQ = 4'b0;
        next_cycle(); next_cycle();
        RESET = 1'b0;
        ptr_m = 0;
    endtask

    // One transfer. abort: 0 none, 2 drop HLDA in S2, 3 RESET in S3.
    task automatic do_xfer(input logic [3:0] dreq, input logic [3:0] mask, input logic [7:0] cmd,
                           input logic [7:0] mode, input int hdelay, input int abort,
                           input bit tc, input int eop_stage);
        logic [3:0] elig;
        logic [1:0] t;
        bit         e;
        int         c;
        next_cycle();
        commandReg = cmd; maskReg = mask; modeXfer = mode; DREQ = dreq;
        elig = cmd[2] ? 4'b0000 : (dreq & ~mask);
        if (elig == 4'b0000) begin
            repeat (4) begin
                next_cycle();
                chk("no_hrq_when_ineligible", {15'b0, HRQ}, 16'h0000);
            end
            DREQ = 4'b0;
            return;
        end
        c = arb(elig, cmd[4]);
        t = mode[2*c +: 2];
        e = (abort == 0) && (tc || eop_stage == 2 || eop_stage == 3);
        exp_q.push_back({2'(abort), e, t, 4'(1 << c)});
        next_cycle();
        chk("hrq_latency", {11'b0, HRQ, DACK}, 16'h0010);
        repeat (hdelay) begin
            next_cycle();
            chk("s0_wait", {11'b0, HRQ, DACK}, 16'h0010);
        end
        HLDA = 1'b1;
        next_cycle();                       // S1
        next_cycle();                       // S2
        if (eop_stage == 2) EOP_N = 1'b0;
        if (abort == 2) begin HLDA = 1'b0; DREQ = 4'b0; end
        next_cycle();                       // S3, or SI after abort
        EOP_N = 1'b1;
        if (abort == 2) return;
        if (eop_stage == 3) EOP_N = 1'b0;
        if (abort == 3) begin RESET = 1'b1; HLDA = 1'b0; DREQ = 4'b0; end
        next_cycle();                       // S4, or SI after reset
        EOP_N = 1'b1;
        if (abort == 3) begin
            ptr_m = 0;
            next_cycle();
            RESET = 1'b0;
            return;
        end
        tcIn = tc; DREQ = 4'b0;
        next_cycle();                       // SI
        tcIn = 1'b0; HLDA = 1'b0;
        ptr_m = (c + 1) % 4;
    endtask

    task automatic s0_drop(input logic [3:0] dreq);
        next_cycle();
        commandReg = 8'h00; maskReg = 4'b0; DREQ = dreq;
        next_cycle();
        chk("s0_drop_hrq_up", {15'b0, HRQ}, 16'h0001);
        DREQ = 4'b0;
        next_cycle();
        chk("s0_drop_back_to_idle", out_vec, exp_vec(0, 4'b0, 2'b0, 1'b0, HLDA));
    endtask

    task automatic back_to_back(input int n);
        int c, target, budget;
        do_reset();
        commandReg = 8'h10; maskReg = 4'b0; modeXfer = 8'h1B;
        for (int k = 0; k < n; k++) begin
            c = arb(4'b1111, 1'b1);
            exp_q.push_back({2'b00, 1'b0, modeXfer[2*c +: 2], 4'(1 << c)});
            ptr_m = (c + 1) % 4;
        end
        target = done + n;
        budget = 0;
        HLDA = 1'b1; DREQ = 4'b1111;
        while (done < target && budget < 80) begin
            next_cycle();
            budget++;
        end
        if (done < target) chk("b2b_timeout", 16'(done), 16'(target));
        DREQ = 4'b0; HLDA = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        logic [8:0] rec;
        int         ab;
        forever begin
            @(negedge CLK);
            if (loadAddr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", {7'b0, DACK, 5'b0}, 16'h0000);
                end else begin
                    rec = exp_q.pop_front();
                    ab  = int'(rec[8:7]);
                    for (int s = 1; s <= 5; s++) begin
                        if (s > 1) @(negedge CLK);
                        if ((ab != 0 && s == ab + 1) || s == 5) begin
                            chk("idle_after_xfer", out_vec, exp_vec(0, 4'b0, 2'b0, 1'b0, HLDA));
                            break;
                        end
                        chk($sformatf("stage_S%0d", s), out_vec,
                            exp_vec(s, rec[3:0], rec[5:4], rec[6], HLDA));
                        if (s == 4) done++;
                    end
                end
            end
        end
    end

    // main stimulus
    initial begin
        RESET = 1'b1; HLDA = 1'b0; EOP_N = 1'b1; tcIn = 1'b0;
        DREQ = 4'b0; maskReg = 4'b0; commandReg = 8'h00; modeXfer = 8'h00;
        next_cycle(); next_cycle();
        chk("reset_outputs", out_vec, exp_vec(0, 4'b0, 2'b0, 1'b0, 1'b0));
        chk("reset_state", {13'b0, fsm_state}, {13'b0, SI});
        RESET = 1'b0;

        // fixed priority, then the lower request alone
        do_xfer(4'b1010, 4'b0000, 8'h00, 8'b01_00_10_00, 0, 0, 1'b0, 0);
        do_xfer(4'b1000, 4'b0000, 8'h00, 8'b01_00_10_00, 2, 0, 1'b0, 0);
        // read on ch2, terminal count, EOP in S3
        do_xfer(4'b0100, 4'b0000, 8'h00, 8'b00_10_00_00, 1, 0, 1'b0, 0);
        do_xfer(4'b0100, 4'b0000, 8'h00, 8'b00_01_00_00, 0, 0, 1'b1, 0);
        do_xfer(4'b0001, 4'b0000, 8'h00, 8'b00_00_00_10, 0, 0, 1'b0, 3);
        do_xfer(4'b0010, 4'b0001, 8'h00, 8'b00_00_01_00, 0, 0, 1'b0, 2);

        // rotating priority, back to back with HLDA held
        back_to_back(5);

        // abort in S2 leaves rotation untouched
        do_xfer(4'b1111, 4'b0000, 8'h10, 8'hA5, 0, 2, 1'b0, 0);
        do_xfer(4'b1111, 4'b0000, 8'h10, 8'hA5, 1, 0, 1'b0, 0);
        s0_drop(4'b0100);

        // reset in S3, then controller disabled
        do_xfer(4'b0011, 4'b0000, 8'h10, 8'h66, 0, 3, 1'b0, 0);
        do_xfer(4'b0001, 4'b0000, 8'h04, 8'h00, 0, 0, 1'b0, 0);
        do_xfer(4'b0100, 4'b0100, 8'h00, 8'h00, 0, 0, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] cmd;
            int ab, es;
            cmd = {3'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 7) == 0), 2'b0};
            ab  = ($urandom_range(0, 3) == 0) ? 2 : 0;
            es  = $urandom_range(0, 3);
            if (es == 1) es = 0;
            do_xfer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                    cmd, 8'($urandom), $urandom_range(0, 3), ab, 1'($urandom_range(0, 1)), es);
        end

        repeat (8) next_cycle();
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dma_timing_control.md
# dma_timing_control

Sequencing and arbitration block for the 4-channel DMA controller. It takes channel requests (DREQ), picks one by fixed or rotating priority, and runs the HRQ/HLDA bus handshake. It then steps the single-transfer timing states and drives the datapath control strobes (`loadAddr`, `updateCurrentAddressReg`, `updateCurrentWordCountReg`, `intEOP`, `programCondition`) plus the external bus strobes. It sits beside the datapath and consumes its command, mode and mask state.

## Interface
- `CHANNELS`, 4: number of DMA channels (only 4 supported).
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DREQ`  in  CHANNELS  channel requests, active-high, level.
- `HLDA`  in  1  CPU hold acknowledge.
- `EOP_N`  in  1  external end-of-process, active-low.
- `commandReg`  in  8  bit2 = controller disable, bit4 = rotating priority; other bits ignored.
- `maskReg`  in  CHANNELS  1 = channel masked.
- `modeXfer`  in  2*CHANNELS  per-channel transfer type (`[2n+1:2n]`): 00 verify, 01 write (I/O→mem), 10 read (mem→I/O), 11 illegal (treated as verify).
- `tcIn`  in  1  datapath: current word count of granted channel is zero (last transfer).
- `HRQ`  out  1  hold request to CPU.
- `DACK`  out  CHANNELS  one-hot acknowledge, active-high.
- `AEN`, `ADSTB`  out  1  address enable / upper-address strobe.
- `MEMR_N`, `MEMW_N`, `IOR_N`, `IOW_N`  out  1  bus strobes, active-low.
- `loadAddr`, `updateCurrentAddressReg`, `updateCurrentWordCountReg`, `intEOP`, `programCondition`  out  1  datapath controls.

## Operation
- States: SI (idle), S0 (hold requested), S1 (address), S2 (read), S3 (write), S4 (finish).
- Outputs are Moore-decoded from registered state and grant.
- SI: eligible = `DREQ & ~maskReg` when `commandReg[2]=0`, else none. If eligible≠0, latch the one-hot grant and go to S0.
- Fixed priority: ch0 highest. Rotating priority: after a channel completes S4, it becomes lowest; rotation pointer resets to ch0 highest.
- S0: HRQ=1. Stay until HLDA=1, then go to S1. DREQ drop in S0 returns to SI and does not rotate.
- S1: AEN=1, ADSTB=1, loadAddr=1, DACK=grant.
- S2: read strobe low. MEMR_N for read, IOR_N for write, none for verify.
- S3: S2 strobe plus write strobe low. IOW_N for read, MEMW_N for write.
- S4: strobes high; updateCurrentAddressReg=1, updateCurrentWordCountReg=1. intEOP=1 if `tcIn` or EOP_N was sampled low in S2 or S3. Next state SI; rotation updates.
- HRQ=1 in S0–S4; AEN=1 and DACK=grant in S1–S4; strobes only in S2–S3.
- programCondition=1 only in SI with HLDA=0.
- HLDA falling in S1–S3: abort to SI next cycle. No update pulses, no intEOP, no rotation.
- `commandReg`/`maskReg` changes affect only the next SI arbitration, never a transfer in flight.
- RESET wins over everything. Reset values: state SI, HRQ=0, DACK=0, AEN=0, ADSTB=0, all strobes 1, loadAddr/update/intEOP=0, programCondition=1 (given HLDA=0), rotation pointer = ch0.

## Timing
- DREQ sampled high in SI at edge t: HRQ=1 from t+1.
- HLDA sampled high at edge h: S1 during h+1, S2 h+2, S3 h+3, S4 h+4, SI h+5.
- Minimum DREQ→HRQ latency 1 cycle; HLDA→DACK latency 1 cycle. DACK width 4 cycles.
- loadAddr, update pulses and intEOP are exactly 1 cycle wide.
- Back-to-back: a still-asserted request re-arbitrates in the SI cycle after S4, so each transfer costs at least 6 cycles.

## Structure
- `dmaRegConfigPkg` holds:
  - the `CHANNELS` constant;
  - the state enum typedef (SI, S0–S4);
  - transfer-type enum;
  - command-bit index constants (`CMD_DISABLE=2`, `CMD_ROTATE=4`).
- Sub-module `dma_priority_resolver`: combinational; eligible vector + rotation pointer + rotate enable → one-hot grant.

## Test plan
- Fixed priority: DREQ=4'b1010, HLDA held high → DACK=4'b0010 in S1–S4, then 4'b1000 on the next transfer.
- Rotating priority: `commandReg[4]=1`, DREQ=4'b1111 held → grant order ch0, ch1, ch2, ch3, ch0.
- Read transfer on ch2: `modeXfer[5:4]=10` → MEMR_N low in S2–S3, IOW_N low in S3 only. One loadAddr pulse in S1; update pulses in S4.
- Terminal count: `tcIn=1` during S4 → intEOP=1 for one cycle. Repeat with EOP_N low in S3 → intEOP=1.
- HLDA dropped in S2 → SI next cycle, all strobes high, DACK=0, no update pulses, grant order unchanged.
- RESET asserted in S3, and `commandReg[2]=1` with DREQ=4'b0001 → outputs at reset values next cycle; no HRQ while disabled.
